// File: rtl/ffmac_mul_sched.sv
// Dot-product sequencer for an external pipelined 7b x 32b multiplier.
// Optional feature macro FFMAC_SAT_EN: saturating accumulator with sticky res_sat.
module ffmac_mul_sched #(
    parameter int unsigned A_W     = 7,
    parameter int unsigned B_W     = 32,
    parameter int unsigned P_W     = 39,
    parameter int unsigned ACC_W   = 48,
    parameter int unsigned MUL_LAT = 2,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [A_W-1:0]   in_a,
    input  logic [B_W-1:0]   in_b,
    output logic             mul_ce,
    output logic [A_W-1:0]   mul_a,
    output logic [B_W-1:0]   mul_b,
    input  logic [P_W-1:0]   mul_p,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [ACC_W-1:0] res_data,
    output logic             res_sat
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HOLD
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   len_q;
    logic [MUL_LAT-1:0] tag;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_sum;
    logic [ACC_W-1:0]   p_ext;
    logic               hs;
    logic               acc_en;
    logic               start_ok;

    assign hs       = in_valid & in_ready;
    assign cnt_inc  = cnt + CNT_W'(1);
    assign p_ext    = {{(ACC_W-P_W){mul_p[P_W-1]}}, mul_p};
    // The oldest tag bit lines up with the product leaving the multiplier.
    assign acc_en   = mul_ce & tag[MUL_LAT-1];
    assign start_ok = (state == IDLE) & start;
    assign res_data = acc;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        mul_ce    = 1'b0;
        res_valid = 1'b0;
        busy      = 1'b1;
        mul_a     = '0;
        mul_b     = '0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = (len != '0) ? RUN : HOLD;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                mul_ce   = 1'b1;
                mul_a    = in_a;
                mul_b    = in_b;
                if (hs && (cnt_inc == len_q)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                mul_ce = 1'b1;
                if (tag[MUL_LAT-1] && (tag[MUL_LAT-2:0] == '0)) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef FFMAC_SAT_EN
    logic [ACC_W:0] sum_w;
    logic           ovf;
    logic           sat;

    // One guard bit: overflow whenever the two top bits of the sum disagree.
    assign sum_w   = {acc[ACC_W-1], acc} + {p_ext[ACC_W-1], p_ext};
    assign ovf     = sum_w[ACC_W] ^ sum_w[ACC_W-1];
    assign acc_sum = !ovf         ? sum_w[ACC_W-1:0] :
                     sum_w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} :
                                    {1'b0, {(ACC_W-1){1'b1}}};
    assign res_sat = sat;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat <= 1'b0;
        end else if (start_ok) begin
            sat <= 1'b0;
        end else if (acc_en && ovf) begin
            sat <= 1'b1;
        end
    end
`else
    assign acc_sum = acc + p_ext;
    assign res_sat = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            tag   <= '0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                acc <= '0;
                cnt <= '0;
                if (len != '0) begin
                    len_q <= len;
                end
            end else if (acc_en) begin
                acc <= acc_sum;
            end
            if (hs) begin
                cnt <= cnt_inc;
            end
            if (mul_ce) begin
                tag <= {tag[MUL_LAT-2:0], hs};
            end
        end
    end

endmodule

// File: tb/tb_ffmac_mul_sched.sv
// Self-checking bench for ffmac_mul_sched with a behavioural 2-stage multiplier
// and a queue-based dot-product reference model (honours FFMAC_SAT_EN).
module tb_ffmac_mul_sched;

    localparam int A_W   = 7;
    localparam int B_W   = 32;
    localparam int P_W   = 39;
    localparam int ACC_W = 48;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] len;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [A_W-1:0]   in_a;
    logic [B_W-1:0]   in_b;
    logic             mul_ce;
    logic [A_W-1:0]   mul_a;
    logic [B_W-1:0]   mul_b;
    logic [P_W-1:0]   mul_p;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] res_data;
    logic             res_sat;

    int checks = 0;
    int errors = 0;

    logic [A_W-1:0] qa[$];
    logic [B_W-1:0] qb[$];

    always #5 clk = ~clk;

    ffmac_mul_sched dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .len      (len),
        .busy     (busy),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .mul_ce   (mul_ce),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_sat  (res_sat)
    );

    // External multiplier: two ce-enabled register stages.
    logic [P_W-1:0] mst1, mst2;
    always @(posedge clk) begin
        if (mul_ce) begin
            mst1 <= P_W'(longint'(mul_a) * longint'($signed(mul_b)));
            mst2 <= mst1;
        end
    end
    assign mul_p = mst2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic void ref_dot(output logic [ACC_W-1:0] res, output logic sat);
        longint acc = 0;
        longint hi  = (longint'(1) <<< (ACC_W-1)) - 1;
        longint lo  = -(longint'(1) <<< (ACC_W-1));
        sat = 1'b0;
        foreach (qa[i]) begin
            acc += longint'(qa[i]) * longint'($signed(qb[i]));
`ifdef FFMAC_SAT_EN
            if (acc > hi) begin
                acc = hi;
                sat = 1'b1;
            end else if (acc < lo) begin
                acc = lo;
                sat = 1'b1;
            end
`else
            if (hi < lo) sat = 1'b1;
`endif
        end
        res = ACC_W'(acc);
    endfunction

    task automatic chk_quiet(input string name);
        chk({name, " busy"},      64'(busy),      64'(0));
        chk({name, " in_ready"},  64'(in_ready),  64'(0));
        chk({name, " mul_ce"},    64'(mul_ce),    64'(0));
        chk({name, " mul_a"},     64'(mul_a),     64'(0));
        chk({name, " mul_b"},     64'(mul_b),     64'(0));
        chk({name, " res_valid"}, 64'(res_valid), 64'(0));
        chk({name, " res_data"},  64'(res_data),  64'(0));
        chk({name, " res_sat"},   64'(res_sat),   64'(0));
    endtask

    // gap < 0: random 0..3 bubbles before each beat; otherwise fixed gap between beats.
    task automatic run_dot(input string name, input int gap, input int hold_cycles);
        int               n;
        logic [ACC_W-1:0] er;
        logic             es;
        n = qa.size();
        ref_dot(er, es);
        start    = 1'b1;
        len      = CNT_W'(n);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        chk({name, " busy"}, 64'(busy), 64'(1));
        if (n == 0) begin
            chk({name, " zero mul_ce"}, 64'(mul_ce), 64'(0));
        end else begin
            for (int i = 0; i < n; i++) begin
                int g;
                g = (gap < 0) ? int'($urandom_range(0, 3)) : ((i == 0) ? 0 : gap);
                in_valid = 1'b0;
                in_a     = A_W'($urandom);
                in_b     = $urandom;
                repeat (g) begin
                    chk({name, " bubble in_ready"}, 64'(in_ready), 64'(1));
                    chk({name, " bubble mul_ce"},   64'(mul_ce),   64'(1));
                    tick();
                end
                in_valid = 1'b1;
                in_a     = qa[i];
                in_b     = qb[i];
                #1;
                chk({name, " in_ready"}, 64'(in_ready), 64'(1));
                chk({name, " mul_a"},    64'(mul_a),    64'(qa[i]));
                chk({name, " mul_b"},    64'(mul_b),    64'(qb[i]));
                tick();
            end
            in_valid = 1'b0;
            chk({name, " in_ready drop"}, 64'(in_ready),  64'(0));
            chk({name, " drain mul_ce"},  64'(mul_ce),    64'(1));
            chk({name, " lat+1"},         64'(res_valid), 64'(0));
            tick();
            chk({name, " lat+2"},         64'(res_valid), 64'(0));
            tick();
        end
        chk({name, " res_valid"},    64'(res_valid), 64'(1));
        chk({name, " res_data"},     64'(res_data),  64'(er));
        chk({name, " res_sat"},      64'(res_sat),   64'(es));
        chk({name, " hold mul_ce"},  64'(mul_ce),    64'(0));
        chk({name, " hold in_ready"},64'(in_ready),  64'(0));
        res_ready = 1'b0;
        for (int k = 0; k < hold_cycles; k++) begin
            start = (k % 2 == 0);
            len   = CNT_W'($urandom_range(1, 9));
            tick();
            chk({name, " bp res_valid"}, 64'(res_valid), 64'(1));
            chk({name, " bp res_data"},  64'(res_data),  64'(er));
            chk({name, " bp in_ready"},  64'(in_ready),  64'(0));
            chk({name, " bp mul_ce"},    64'(mul_ce),    64'(0));
        end
        start     = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({name, " release res_valid"}, 64'(res_valid), 64'(0));
        chk({name, " release busy"},      64'(busy),      64'(0));
    endtask

    initial begin
        logic [ACC_W-1:0] ovf_exp;
        reset     = 1'b1;
        start     = 1'b0;
        len       = '0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        res_ready = 1'b0;
        tick();
        tick();
        chk_quiet("reset held");
        reset = 1'b0;
        tick();
        chk_quiet("after reset");

        qa = '{7'd5, 7'd127, 7'd0};
        qb = '{32'd10, 32'hFFFF_FFFF, 32'd1000};
        run_dot("basic", 0, 0);
        chk("basic const", 64'(res_data), 64'(48'hFFFF_FFFF_FFB3));

        qa = '{7'd1, 7'd1, 7'd1, 7'd1};
        qb = '{32'd1, 32'd2, 32'd3, 32'd4};
        run_dot("bubbles", 2, 0);
        chk("bubbles const", 64'(res_data), 64'(10));

        qa.delete();
        qb.delete();
        run_dot("zero", 0, 2);
        chk("zero const", 64'(res_data), 64'(0));

        for (int i = 0; i < 5; i++) begin
            qa.push_back(A_W'($urandom));
            qb.push_back($urandom);
        end
        run_dot("backpressure", 0, 5);

        start = 1'b1;
        len   = CNT_W'(4);
        tick();
        start = 1'b0;
        repeat (2) begin
            in_valid = 1'b1;
            in_a     = A_W'($urandom_range(1, 127));
            in_b     = $urandom;
            tick();
        end
        reset = 1'b1;
        #1;
        chk_quiet("mid-run reset");
        in_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk_quiet("post reset");
        qa = '{7'd3};
        qb = '{32'hFFFF_FFFC};
        run_dot("after abort", 0, 1);
        chk("after abort const", 64'(res_data), 64'(48'hFFFF_FFFF_FFF4));

        repeat (8) begin
            int n;
            n = int'($urandom_range(1, 12));
            qa.delete();
            qb.delete();
            for (int i = 0; i < n; i++) begin
                qa.push_back(A_W'($urandom));
                qb.push_back($urandom);
            end
            run_dot("random", -1, int'($urandom_range(0, 3)));
        end

        qa.delete();
        qb.delete();
        for (int i = 0; i < 600; i++) begin
            qa.push_back(7'd127);
            qb.push_back(32'h7FFF_FFFF);
        end
        run_dot("overflow", 0, 0);
`ifdef FFMAC_SAT_EN
        ovf_exp = 48'h7FFF_FFFF_FFFF;
`else
        ovf_exp = ACC_W'(-64'sd117836722809256);
`endif
        chk("overflow const", 64'(res_data), 64'(ovf_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
